// File: rtl/uart_pkt_parser.sv
// Framed packet parser for a UART byte stream: SYNC, LEN, payload, CHK.
// A checked packet is held in a buffer until the consumer acknowledges it.
module uart_pkt_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Pkt_Valid,
  output logic [7:0] o_Pkt_Len,
  input  logic       i_Pkt_Ack,
  input  logic [7:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

  state_t        state_q;
  logic [7:0]    len_q;
  logic [7:0]    sum_q;
  logic [7:0]    idx_q;
  logic [7:0]    pkt_len_q;
  logic          valid_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic          overrun_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    buf_mem [2**AW];

  logic wr_en;
  logic len_ok;
  logic last_byte;
  logic rd_in_range;

  assign wr_en       = (state_q == S_PAYLOAD) && i_Rx_DV;
  assign len_ok      = (i_Rx_Byte != 8'd0) && ({1'b0, i_Rx_Byte} <= MAX_LEN_W);
  assign last_byte   = (idx_q == len_q - 8'd1);
  assign rd_in_range = ({1'b0, i_Rd_Addr} < MAX_LEN_W);

  // Payload storage: no reset so it maps onto block RAM.
  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      buf_mem[idx_q[AW-1:0]] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rd_data_q <= 8'h00;
    end else if (rd_in_range) begin
      rd_data_q <= buf_mem[i_Rd_Addr[AW-1:0]];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_HUNT;
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      idx_q      <= 8'd0;
      pkt_len_q  <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      overrun_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        S_HUNT: begin
          tmo_q <= '0;
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            state_q <= S_LEN;
          end
        end
        S_LEN, S_PAYLOAD, S_CHK: begin
          // A strobe always wins over an expiring inter-byte timer.
          if (i_Rx_DV) begin
            tmo_q <= '0;
            case (state_q)
              S_LEN: begin
                if (len_ok) begin
                  len_q   <= i_Rx_Byte;
                  sum_q   <= i_Rx_Byte;
                  idx_q   <= 8'd0;
                  state_q <= S_PAYLOAD;
                end else begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd1;
                  state_q    <= S_HUNT;
                end
              end
              S_PAYLOAD: begin
                sum_q <= sum_q + i_Rx_Byte;
                idx_q <= idx_q + 8'd1;
                if (last_byte) begin
                  state_q <= S_CHK;
                end
              end
              default: begin
                if (i_Rx_Byte == sum_q) begin
                  pkt_len_q <= len_q;
                  valid_q   <= 1'b1;
                  state_q   <= S_HOLD;
                end else begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd2;
                  state_q    <= S_HUNT;
                end
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            tmo_q      <= '0;
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
            state_q    <= S_HUNT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_HOLD: begin
          tmo_q <= '0;
          if (i_Rx_DV) begin
            overrun_q <= 1'b1;
          end
          if (i_Pkt_Ack) begin
            valid_q <= 1'b0;
            state_q <= S_HUNT;
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign o_Pkt_Valid = valid_q;
  assign o_Pkt_Len   = pkt_len_q;
  assign o_Rd_Data   = rd_data_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: table of frames plus hand-written
// sequences for timeout, hold/overrun and mid-frame reset.
module tb_uart_pkt_parser;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst, dv, ack;
  logic [7:0] rx, rd_addr;
  logic       pkt_valid, err, overrun;
  logic [7:0] pkt_len, rd_data;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_pkt_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rx),
    .o_Pkt_Valid(pkt_valid),
    .o_Pkt_Len  (pkt_len),
    .i_Pkt_Ack  (ack),
    .i_Rd_Addr  (rd_addr),
    .o_Rd_Data  (rd_data),
    .o_Err      (err),
    .o_Err_Code (err_code),
    .o_Overrun  (overrun)
  );

  typedef struct {
    logic [63:0] bytes;   // first byte in the top octet
    int          n;
    logic        valid;
    logic [7:0]  len;
    logic [7:0]  d0;
    int          errs;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    rx = b;
    @(negedge clk);
    dv = 1'b0;
    rx = 8'h00;
    if (err) err_cnt++;
    if (overrun) ovr_cnt++;
  endtask

  task automatic read_byte(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, int'(pkt_valid), 0);
    chk({tag, "_len"}, int'(pkt_len), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_code"}, int'(err_code), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
    chk({tag, "_rdata"}, int'(rd_data), 0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [63:0] bv;
    int          seen_at;

    vecs[0] = '{64'hA503112233690000, 6, 1'b1, 8'd3, 8'h11, 0, 2'd0};
    vecs[1] = '{64'hA503112233680000, 6, 1'b0, 8'd0, 8'h00, 1, 2'd2};
    vecs[2] = '{64'hA500000000000000, 2, 1'b0, 8'd0, 8'h00, 1, 2'd1};
    vecs[3] = '{64'hA511000000000000, 2, 1'b0, 8'd0, 8'h00, 1, 2'd1};
    vecs[4] = '{64'h00FF12A5017E7F00, 7, 1'b1, 8'd1, 8'h7E, 0, 2'd0};
    vecs[5] = '{64'hA502FF0304000000, 5, 1'b1, 8'd2, 8'hFF, 0, 2'd0};
    vecs[6] = '{64'hA501A5A600000000, 4, 1'b1, 8'd1, 8'hA5, 0, 2'd0};
    vecs[7] = '{64'hA5A5011011000000, 5, 1'b0, 8'd0, 8'h00, 1, 2'd1};

    rst = 1'b1; dv = 1'b0; ack = 1'b0; rx = 8'h00; rd_addr = 8'h00;
    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      err_cnt = 0;
      ovr_cnt = 0;
      bv = vecs[i].bytes;
      for (int k = 0; k < vecs[i].n; k++) begin
        send_byte(bv[63-8*k -: 8]);
      end
      chk($sformatf("v%0d_valid", i), int'(pkt_valid), int'(vecs[i].valid));
      chk($sformatf("v%0d_errs", i), err_cnt, vecs[i].errs);
      chk($sformatf("v%0d_ovr", i), ovr_cnt, 0);
      if (vecs[i].errs > 0) chk($sformatf("v%0d_code", i), int'(err_code), int'(vecs[i].code));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_len", i), int'(pkt_len), int'(vecs[i].len));
        read_byte(8'd0, d);
        chk($sformatf("v%0d_d0", i), int'(d), int'(vecs[i].d0));
        do_ack();
        chk($sformatf("v%0d_ack", i), int'(pkt_valid), 0);
      end
      $display("vec %0d: bytes=%h n=%0d valid=%0b errs=%0d code=%0d", i, bv, vecs[i].n,
               vecs[i].valid, err_cnt, err_code);
    end

    // Good frame: read every payload byte and the out-of-range addresses.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    read_byte(8'd1, d); chk("good_d1", int'(d), 8'h22);
    read_byte(8'd2, d); chk("good_d2", int'(d), 8'h33);
    read_byte(8'd16, d); chk("rd_oob16", int'(d), 0);
    read_byte(8'd255, d); chk("rd_oob255", int'(d), 0);
    do_ack();
    $display("good frame read: valid=%0b", pkt_valid);

    // Maximum-length payload 01..10, checksum 0x98.
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h10);
    for (int k = 1; k <= 16; k++) send_byte(8'(k));
    send_byte(8'h98);
    chk("max_valid", int'(pkt_valid), 1);
    chk("max_len", int'(pkt_len), 16);
    chk("max_errs", err_cnt, 0);
    read_byte(8'd15, d); chk("max_d15", int'(d), 8'h10);
    read_byte(8'd0, d); chk("max_d0", int'(d), 8'h01);
    do_ack();
    $display("max-length frame: len=%0d", pkt_len);

    // Timeout mid-payload, then recovery.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
    seen_at = -1;
    for (int j = 1; j <= 3 * TMO && seen_at < 0; j++) begin
      @(negedge clk);
      if (err) seen_at = j;
    end
    chk("tmo_window", int'(seen_at >= TMO - 1 && seen_at <= TMO), 1);
    chk("tmo_code", int'(err_code), 3);
    @(negedge clk);
    chk("tmo_pulse_width", int'(err), 0);
    chk("tmo_valid", int'(pkt_valid), 0);
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    chk("tmo_next_valid", int'(pkt_valid), 1);
    read_byte(8'd0, d); chk("tmo_next_d0", int'(d), 8'h7E);
    do_ack();
    $display("timeout: err after %0d idle clocks, code=%0d", seen_at, err_code);

    // Strobe lands on the terminal count: the byte must be accepted.
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h02);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h79);
    chk("coinc_valid", int'(pkt_valid), 1);
    chk("coinc_errs", err_cnt, 0);
    chk("coinc_len", int'(pkt_len), 2);
    do_ack();
    $display("timeout/strobe coincidence: valid=%0b errs=%0d", pkt_valid, err_cnt);

    // Held packet: overruns leave the buffer intact.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    ovr_cnt = 0;
    send_byte(8'h99); send_byte(8'hA5);
    chk("hold_ovr", ovr_cnt, 2);
    chk("hold_valid", int'(pkt_valid), 1);
    chk("hold_len", int'(pkt_len), 3);
    read_byte(8'd0, d); chk("hold_d0", int'(d), 8'h11);
    read_byte(8'd1, d); chk("hold_d1", int'(d), 8'h22);
    read_byte(8'd2, d); chk("hold_d2", int'(d), 8'h33);
    @(negedge clk);
    ack = 1'b1; dv = 1'b1; rx = 8'h5A;
    @(negedge clk);
    ack = 1'b0; dv = 1'b0; rx = 8'h00;
    chk("ackdv_ovr", int'(overrun), 1);
    chk("ackdv_valid", int'(pkt_valid), 0);
    $display("hold: overruns=%0d then ack+strobe", ovr_cnt);

    // Reset mid-frame discards it silently.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rd_addr = 8'd0;
    do_reset();
    check_all_zero("midrst");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    chk("post_rst_valid", int'(pkt_valid), 1);
    chk("post_rst_len", int'(pkt_len), 1);
    do_ack();
    $display("mid-frame reset: next frame valid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
